// File: rtl/ff_conv_pkg.sv
// Shared mode encoding for the configurable flip-flop bank.
package ff_conv_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_D  = 2'b00;
    localparam mode_t MODE_T  = 2'b01;
    localparam mode_t MODE_JK = 2'b10;
    localparam mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/ff_conv_bank_if.sv
// Control, data and status bundle between a host and the flip-flop bank.
interface ff_conv_bank_if
    import ff_conv_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             cfg_we;
    mode_t            cfg_mode;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    mode_t            mode;
    logic [WIDTH-1:0] sr_err;
    logic [CNT_W-1:0] chg_cnt;

    modport master (
        output cfg_we, cfg_mode, en, load, ld_val, a, b, err_clr,
        input  q, qn, mode, sr_err, chg_cnt
    );

    modport slave (
        input  cfg_we, cfg_mode, en, load, ld_val, a, b, err_clr,
        output q, qn, mode, sr_err, chg_cnt
    );
endinterface

// File: rtl/ff_conv_cell.sv
// One flip-flop channel: D/T/JK/SR next-state function, load override,
// sticky illegal-SR flag and a flag telling the bank that q is about to change.
module ff_conv_cell
    import ff_conv_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  mode_t mode,
    input  logic  en,
    input  logic  load,
    input  logic  ld_val,
    input  logic  a,
    input  logic  b,
    input  logic  err_clr,
    input  logic  reset_val,
    output logic  q,
    output logic  sr_err,
    output logic  changes
);
    logic q_nxt;
    logic err_set;

    always_comb begin
        q_nxt = q;
        if (load) begin
            q_nxt = ld_val;
        end else if (en) begin
            unique case (mode)
                MODE_D:  q_nxt = a;
                MODE_T:  q_nxt = q ^ a;
                MODE_JK: q_nxt = (a & b) ? ~q : (a ? 1'b1 : (b ? 1'b0 : q));
                // S=R=1 is illegal and holds q
                MODE_SR: q_nxt = (a & b) ? q : (a ? 1'b1 : (b ? 1'b0 : q));
                default: q_nxt = q;
            endcase
        end
    end

    assign err_set = (mode == MODE_SR) && en && !load && a && b;
    assign changes = q_nxt ^ q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= reset_val;
            sr_err <= 1'b0;
        end else begin
            q <= q_nxt;
            // a fresh illegal condition outranks a same-cycle clear
            if (err_set) begin
                sr_err <= 1'b1;
            end else if (err_clr) begin
                sr_err <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/ff_conv_bank.sv
// WIDTH-channel configurable flip-flop bank with a run-time mode register
// and a saturating count of cycles in which any channel changed.
module ff_conv_bank
    import ff_conv_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter int               CNT_W      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter mode_t            RESET_MODE = MODE_T
)(
    input logic            clk,
    input logic            rst_n,
    ff_conv_bank_if.slave  bus
);
    mode_t            mode_r;
    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] err_vec;
    logic [WIDTH-1:0] chg_vec;
    logic [CNT_W-1:0] cnt_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_conv_cell u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .mode      (mode_r),
            .en        (bus.en),
            .load      (bus.load),
            .ld_val    (bus.ld_val[i]),
            .a         (bus.a[i]),
            .b         (bus.b[i]),
            .err_clr   (bus.err_clr),
            .reset_val (RESET_VAL[i]),
            .q         (q_vec[i]),
            .sr_err    (err_vec[i]),
            .changes   (chg_vec[i])
        );
    end

    // cells sample mode_r before this edge updates it, so a write takes effect next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= RESET_MODE;
            cnt_r  <= '0;
        end else begin
            if (bus.cfg_we) begin
                mode_r <= bus.cfg_mode;
            end
            if ((|chg_vec) && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.q       = q_vec;
    assign bus.qn      = ~q_vec;
    assign bus.mode    = mode_r;
    assign bus.sr_err  = err_vec;
    assign bus.chg_cnt = cnt_r;
endmodule

// File: tb/tb_ff_conv_bank.sv
// Directed bench for ff_conv_bank with WIDTH=4, CNT_W=3, reset mode T.
module tb_ff_conv_bank;
    import ff_conv_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ff_conv_bank_if #(.WIDTH(4), .CNT_W(3)) bus ();

    ff_conv_bank #(
        .WIDTH      (4),
        .CNT_W      (3),
        .RESET_VAL  (4'b0000),
        .RESET_MODE (MODE_T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_we   = 1'b0;
        bus.cfg_mode = MODE_D;
        bus.en       = 1'b0;
        bus.load     = 1'b0;
        bus.ld_val   = 4'b0000;
        bus.a        = 4'b0000;
        bus.b        = 4'b0000;
        bus.err_clr  = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.q !== 4'b0000) begin
            errors++; $display("FAIL reset_q got %b exp %b", bus.q, 4'b0000);
        end
        checks++;
        if (bus.qn !== 4'b1111) begin
            errors++; $display("FAIL reset_qn got %b exp %b", bus.qn, 4'b1111);
        end
        checks++;
        if (bus.mode !== MODE_T) begin
            errors++; $display("FAIL reset_mode got %b exp %b", bus.mode, MODE_T);
        end
        checks++;
        if (bus.sr_err !== 4'b0000) begin
            errors++; $display("FAIL reset_sr_err got %b exp %b", bus.sr_err, 4'b0000);
        end
        checks++;
        if (bus.chg_cnt !== 3'd0) begin
            errors++; $display("FAIL reset_cnt got %0d exp %0d", bus.chg_cnt, 0);
        end
    endtask

    task automatic test_toggle();
        logic [3:0] exp_q [3];
        exp_q[0] = 4'b0101; exp_q[1] = 4'b0000; exp_q[2] = 4'b0101;
        bus.en = 1'b1;
        bus.a  = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.q !== exp_q[i]) begin
                errors++; $display("FAIL toggle_q step %0d got %b exp %b", i, bus.q, exp_q[i]);
            end
            checks++;
            if (bus.qn !== ~exp_q[i]) begin
                errors++; $display("FAIL toggle_qn step %0d got %b exp %b", i, bus.qn, ~exp_q[i]);
            end
        end
        checks++;
        if (bus.chg_cnt !== 3'd3) begin
            errors++; $display("FAIL toggle_cnt got %0d exp %0d", bus.chg_cnt, 3);
        end
    endtask

    task automatic test_d_jk();
        // mode write edge still uses T: 0101 ^ 1111
        bus.cfg_we = 1'b1; bus.cfg_mode = MODE_D; bus.a = 4'b1111;
        tick();
        checks++;
        if (bus.q !== 4'b1010) begin
            errors++; $display("FAIL cfg_old_mode_q got %b exp %b", bus.q, 4'b1010);
        end
        checks++;
        if (bus.mode !== MODE_D) begin
            errors++; $display("FAIL cfg_mode_d got %b exp %b", bus.mode, MODE_D);
        end
        bus.cfg_we = 1'b0;
        tick();
        checks++;
        if (bus.q !== 4'b1111) begin
            errors++; $display("FAIL d_mode_q got %b exp %b", bus.q, 4'b1111);
        end
        bus.cfg_we = 1'b1; bus.cfg_mode = MODE_JK;
        tick();
        checks++;
        if (bus.q !== 4'b1111) begin
            errors++; $display("FAIL d_hold_q got %b exp %b", bus.q, 4'b1111);
        end
        bus.cfg_we = 1'b0; bus.a = 4'b0011; bus.b = 4'b0101;
        tick();
        checks++;
        if (bus.q !== 4'b1010) begin
            errors++; $display("FAIL jk_q got %b exp %b", bus.q, 4'b1010);
        end
        checks++;
        if (bus.chg_cnt !== 3'd6) begin
            errors++; $display("FAIL jk_cnt got %0d exp %0d", bus.chg_cnt, 6);
        end
    endtask

    task automatic test_sr_load();
        apply_reset();
        bus.cfg_we = 1'b1; bus.cfg_mode = MODE_SR;
        tick();
        bus.cfg_we = 1'b0; bus.en = 1'b1; bus.a = 4'b1001; bus.b = 4'b1100;
        tick();
        checks++;
        if (bus.q !== 4'b0001) begin
            errors++; $display("FAIL sr_q got %b exp %b", bus.q, 4'b0001);
        end
        checks++;
        if (bus.sr_err !== 4'b1000) begin
            errors++; $display("FAIL sr_err_set got %b exp %b", bus.sr_err, 4'b1000);
        end
        bus.err_clr = 1'b1; bus.a = 4'b1000; bus.b = 4'b1000;
        tick();
        checks++;
        if (bus.sr_err !== 4'b1000) begin
            errors++; $display("FAIL sr_set_wins got %b exp %b", bus.sr_err, 4'b1000);
        end
        checks++;
        if (bus.q !== 4'b0001) begin
            errors++; $display("FAIL sr_illegal_hold got %b exp %b", bus.q, 4'b0001);
        end
        bus.a = 4'b0000; bus.b = 4'b0000;
        tick();
        checks++;
        if (bus.sr_err !== 4'b0000) begin
            errors++; $display("FAIL sr_err_clr got %b exp %b", bus.sr_err, 4'b0000);
        end
        bus.err_clr = 1'b0; bus.a = 4'b0010; bus.b = 4'b0010;
        tick();
        checks++;
        if (bus.sr_err !== 4'b0010) begin
            errors++; $display("FAIL sr_err_bit1 got %b exp %b", bus.sr_err, 4'b0010);
        end
        bus.en = 1'b0; bus.load = 1'b1; bus.ld_val = 4'b0110;
        bus.a = 4'b1111; bus.b = 4'b1111;
        tick();
        checks++;
        if (bus.q !== 4'b0110) begin
            errors++; $display("FAIL load_q got %b exp %b", bus.q, 4'b0110);
        end
        checks++;
        if (bus.sr_err !== 4'b0010) begin
            errors++; $display("FAIL load_sr_err got %b exp %b", bus.sr_err, 4'b0010);
        end
        checks++;
        if (bus.chg_cnt !== 3'd2) begin
            errors++; $display("FAIL load_cnt got %0d exp %0d", bus.chg_cnt, 2);
        end
        // load with en=1 must also win over the SR function and not flag errors
        bus.en = 1'b1; bus.ld_val = 4'b1001;
        tick();
        checks++;
        if (bus.q !== 4'b1001) begin
            errors++; $display("FAIL load_en_q got %b exp %b", bus.q, 4'b1001);
        end
        checks++;
        if (bus.sr_err !== 4'b0010) begin
            errors++; $display("FAIL load_en_sr_err got %b exp %b", bus.sr_err, 4'b0010);
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        logic [2:0] exp_cnt;
        apply_reset();
        bus.en = 1'b1; bus.a = 4'b0001;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_cnt = (i < 7) ? 3'(i) : 3'd7;
            checks++;
            if (bus.chg_cnt !== exp_cnt) begin
                errors++; $display("FAIL sat_cnt edge %0d got %0d exp %0d", i, bus.chg_cnt, exp_cnt);
            end
        end
        checks++;
        if (bus.q !== 4'b0000) begin
            errors++; $display("FAIL sat_q got %b exp %b", bus.q, 4'b0000);
        end
        apply_reset();
        bus.en = 1'b1; bus.a = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.chg_cnt !== 3'd3 || bus.q !== 4'b0001) begin
            errors++; $display("FAIL en_low_hold got cnt %0d q %b exp cnt 3 q 0001", bus.chg_cnt, bus.q);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.cfg_we = 1'b1; bus.cfg_mode = MODE_SR;
        tick();
        bus.cfg_we = 1'b0; bus.en = 1'b1; bus.a = 4'b1000; bus.b = 4'b1000;
        tick();
        bus.a = 4'b0001; bus.b = 4'b0000;
        tick();
        checks++;
        if (bus.q !== 4'b0001 || bus.sr_err !== 4'b1000 || bus.chg_cnt !== 3'd1) begin
            errors++; $display("FAIL pre_reset got q %b err %b cnt %0d exp q 0001 err 1000 cnt 1",
                               bus.q, bus.sr_err, bus.chg_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.q !== 4'b0000 || bus.qn !== 4'b1111 || bus.mode !== MODE_T) begin
            errors++; $display("FAIL async_q_mode got q %b qn %b mode %b exp q 0000 qn 1111 mode 01",
                               bus.q, bus.qn, bus.mode);
        end
        checks++;
        if (bus.sr_err !== 4'b0000 || bus.chg_cnt !== 3'd0) begin
            errors++; $display("FAIL async_err_cnt got err %b cnt %0d exp err 0000 cnt 0",
                               bus.sr_err, bus.chg_cnt);
        end
        #1 rst_n = 1'b1;
        bus.a = 4'b0011;
        tick();
        checks++;
        if (bus.q !== 4'b0011 || bus.chg_cnt !== 3'd1) begin
            errors++; $display("FAIL post_reset got q %b cnt %0d exp q 0011 cnt 1", bus.q, bus.chg_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_inputs();
        test_reset();
        test_toggle();
        test_d_jk();
        test_sr_load();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ff_conv_bank.md
Name: ff_conv_bank

Overview:
- Parametrised bank of WIDTH flip-flop channels. Every channel runs as a D, T, JK or SR flip-flop, chosen at run time by a shared mode register.
- Generalises the single SR-derived T flip-flop into one reusable block. Adds clock enable, parallel load, a sticky illegal-SR flag per channel and a saturating activity counter.
- Used wherever the design needs a small configurable state register or a toggle bank.

Parameters:
- WIDTH, 4, number of flip-flop channels.
- CNT_W, 8, width of the activity counter chg_cnt.
- RESET_VAL, 0 (WIDTH bits), value of q after reset.
- RESET_MODE, 2'b01 (T), value of the mode register after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  writes cfg_mode into the mode register.
- cfg_mode  in  2  new mode: 00 D, 01 T, 10 JK, 11 SR.
- en  in  1  clock enable for the flip-flop function.
- load  in  1  parallel load of ld_val into q.
- ld_val  in  WIDTH  value for parallel load.
- a  in  WIDTH  per-channel input 1: d / t / j / s, depending on mode.
- b  in  WIDTH  per-channel input 2: k / r; ignored in D and T modes.
- err_clr  in  1  clears all bits of sr_err.
- q  out  WIDTH  flip-flop state.
- qn  out  WIDTH  combinational ~q.
- mode  out  2  current mode register value.
- sr_err  out  WIDTH  sticky flag per channel: illegal S=R=1 was applied.
- chg_cnt  out  CNT_W  count of cycles in which q changed; saturates.

Behaviour:
- Reset (rst_n=0, asynchronous, any time): q=RESET_VAL, qn=~RESET_VAL, mode=RESET_MODE, sr_err=0, chg_cnt=0. Reset mid-operation aborts everything immediately. First update after release is on the first rising edge with rst_n=1.
- Mode register: on an edge with cfg_we=1, mode takes cfg_mode. The q update in that same cycle uses the OLD mode. The new mode applies from the next edge.
- q next-state priority per edge: load=1 -> q<=ld_val, regardless of en or mode. Else en=0 -> hold. Else apply the per-channel function for the current mode:
  - D: q<=a.
  - T: q<=q^a.
  - JK: 00 hold, 01 reset to 0, 10 set to 1, 11 toggle.
  - SR: 00 hold, 01 reset to 0, 10 set to 1, 11 illegal -> hold q.
- Latency: one clock from inputs to q; no combinational path from inputs to q.
- sr_err[i] is set on an edge where mode=SR, en=1, load=0, a[i]=1 and b[i]=1.
- err_clr=1 clears all sr_err bits on that edge. If a set condition occurs in the same cycle, the set wins for that channel.
- Outside SR mode, and whenever load=1, sr_err never sets.
- chg_cnt increments by 1 on any edge where the q next-state differs from the current q in at least one bit. This covers load as well as function updates.
- chg_cnt saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset.
- Widths: a, b, ld_val, q, sr_err are all exactly WIDTH. No sign extension or truncation.

Decomposition:
- Package ff_conv_pkg:
  - mode constants MODE_D=2'b00, MODE_T=2'b01, MODE_JK=2'b10, MODE_SR=2'b11.
  - 2-bit mode typedef.
- Sub-module ff_conv_cell, one instance per channel:
  - Ports: clk, rst_n, mode, en, load, ld_val bit, a bit, b bit, err_clr, RESET_VAL bit.
  - Outputs: q, sr_err, and a "changes" bit.
- Top level holds the mode register, the OR-reduction of the per-cell "changes" bits and the saturating counter.

Test Plan (WIDTH=4, CNT_W=3, RESET_VAL=0, RESET_MODE=T):
- Reset then T mode: en=1, a=4'b0101 for 3 edges -> q goes 0101, 0000, 0101; chg_cnt=3; qn=~q at every step.
- D then JK:
  - cfg_we=1, cfg_mode=D, a=4'b1111 -> q toggles per old T mode, not loaded; next edge q=1111.
  - Switch to JK with a=4'b0011, b=4'b0101 -> q=4'b1010 after one edge (channels: toggle, set, reset, hold).
- SR illegal: mode=SR, q=0, en=1, a=4'b1001, b=4'b1100 -> q=4'b0001, sr_err=4'b1000. With err_clr=1 and a=b=4'b1000 in the same cycle -> sr_err stays 4'b1000.
- Load priority: en=0, load=1, ld_val=4'b0110 in SR mode with a=b=4'b1111 -> q=0110; sr_err unchanged; chg_cnt +1.
- Saturation: T mode, a=4'b0001, en=1 for 10 edges -> chg_cnt stops at 7. Holding en=0 -> no increment.
- Async reset mid-run: drop rst_n between edges -> q, mode, sr_err, chg_cnt return to reset values before the next edge. Release -> normal operation resumes.
